// File: rtl/sgm_pkg.sv
// sgm_pkg: shared constants and state encoding for the sample playback path.
package sgm_pkg;
    localparam int SGM_WORD_W = 32;
    localparam int SGM_SAMPLE_W = 8;
    localparam int SGM_DAC_W = 12;
    localparam int SGM_BYTES_PER_WORD = SGM_WORD_W / SGM_SAMPLE_W;
    localparam logic [SGM_DAC_W-1:0] SGM_MIDSCALE = 12'h080;
    typedef enum logic [1:0] {IDLE, PRIME, PLAY, STALL} state_e;
endpackage

// File: rtl/sample_rate_divider.sv
// sample_rate_divider: counts clocks between samples; restart forces an immediate tick.
module sample_rate_divider #(
    parameter int DIV_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             restart,
    input  logic [DIV_W-1:0] div_m1,
    output logic             tick
);
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;

    always_comb begin
        tick = en && (restart || div_cnt_q == div_m1);
        div_cnt_d = (en && !tick) ? div_cnt_q + 1'b1 : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) div_cnt_q <= '0;
        else          div_cnt_q <= div_cnt_d;
    end
endmodule

// File: rtl/sample_playback_streamer.sv
// sample_playback_streamer: unpacks FIFO words low byte first and paces the
// resulting 8-bit samples onto the DAC amplitude at a programmable rate.
module sample_playback_streamer
    import sgm_pkg::*;
#(
    parameter int WORD_W = SGM_WORD_W,
    parameter int SAMPLE_W = SGM_SAMPLE_W,
    parameter int DAC_W = SGM_DAC_W,
    parameter int DIV_W = 32,
    parameter logic [DAC_W-1:0] MIDSCALE = SGM_MIDSCALE
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              play_trig,
    input  logic              stop,
    input  logic [DIV_W-1:0]  rate_div,
    input  logic [DIV_W-1:0]  total_samples,
    input  logic [WORD_W-1:0] fifo_dout,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    output logic [DAC_W-1:0]  ampl,
    output logic              busy,
    output logic              underrun,
    output logic              done
);
    localparam int NB = WORD_W / SAMPLE_W;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;

    state_e            state_q, state_d;
    logic [2:0]        trig_sync_q, trig_sync_d;
    logic [DIV_W-1:0]  rate_q, rate_d, total_q, total_d, sample_cnt_q, sample_cnt_d;
    logic [WORD_W-1:0] cur_word_q, cur_word_d, nxt_word_q, nxt_word_d;
    logic              nxt_valid_q, nxt_valid_d, rd_en_q, rd_en_d, rd_pend_q, rd_pend_d;
    logic              play_entry_q, play_entry_d, done_q, done_d, underrun_q, underrun_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DAC_W-1:0]  ampl_q, ampl_d;
    logic [DIV_W-1:0]  div_m1, cnt_inc;
    logic              trig_edge, tick, last_byte;

    assign trig_edge = trig_sync_q[1] & ~trig_sync_q[2];
    assign div_m1 = (rate_q == '0) ? '0 : rate_q - 1'b1;
    assign cnt_inc = sample_cnt_q + 1'b1;
    assign last_byte = (idx_q == IW'(NB - 1));

    sample_rate_divider #(.DIV_W(DIV_W)) u_div (
        .clk(clk), .reset_n(reset_n), .en(state_q == PLAY),
        .restart(play_entry_q), .div_m1(div_m1), .tick(tick)
    );

    always_comb begin
        state_d = state_q;
        trig_sync_d = {trig_sync_q[1:0], play_trig};
        rate_d = rate_q;
        total_d = total_q;
        sample_cnt_d = sample_cnt_q;
        cur_word_d = cur_word_q;
        idx_d = idx_q;
        ampl_d = ampl_q;
        underrun_d = underrun_q;
        done_d = 1'b0;
        play_entry_d = 1'b0;
        rd_pend_d = rd_en_q;
        nxt_word_d = rd_pend_q ? fifo_dout : nxt_word_q;
        nxt_valid_d = nxt_valid_q | rd_pend_q;
        case (state_q)
            IDLE: begin
                ampl_d = MIDSCALE;
                nxt_valid_d = 1'b0;
                if (trig_edge) begin
                    rate_d = rate_div;
                    total_d = total_samples;
                    underrun_d = 1'b0;
                    sample_cnt_d = '0;
                    idx_d = '0;
                    state_d = PRIME;
                end
            end
            PRIME, STALL: begin
                if (state_q == STALL) underrun_d = 1'b1;
                if (nxt_valid_q) begin
                    cur_word_d = nxt_word_q;
                    nxt_valid_d = 1'b0;
                    idx_d = '0;
                    play_entry_d = 1'b1;
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if (tick) begin
                    ampl_d = {{(DAC_W-SAMPLE_W){1'b0}}, cur_word_q[SAMPLE_W*int'(idx_q) +: SAMPLE_W]};
                    idx_d = last_byte ? '0 : idx_q + 1'b1;
                    sample_cnt_d = (&sample_cnt_q) ? sample_cnt_q : cnt_inc;
                    if (last_byte && nxt_valid_q) begin
                        cur_word_d = nxt_word_q;
                        nxt_valid_d = 1'b0;
                    end else if (last_byte) begin
                        state_d = STALL;
                    end
                    if (total_q != '0 && cnt_inc == total_q) begin
                        done_d = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // abort overrides completion; an in-flight read still lands and is dropped in IDLE
        if (state_q != IDLE && stop) begin
            state_d = IDLE;
            ampl_d = MIDSCALE;
            done_d = 1'b0;
        end
        rd_en_d = (state_d != IDLE) && !nxt_valid_d && !rd_en_q && !rd_pend_q && !fifo_empty;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            trig_sync_q <= '0;
            rate_q <= '0;
            total_q <= '0;
            sample_cnt_q <= '0;
            cur_word_q <= '0;
            nxt_word_q <= '0;
            nxt_valid_q <= 1'b0;
            rd_en_q <= 1'b0;
            rd_pend_q <= 1'b0;
            play_entry_q <= 1'b0;
            idx_q <= '0;
            ampl_q <= MIDSCALE;
            done_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            trig_sync_q <= trig_sync_d;
            rate_q <= rate_d;
            total_q <= total_d;
            sample_cnt_q <= sample_cnt_d;
            cur_word_q <= cur_word_d;
            nxt_word_q <= nxt_word_d;
            nxt_valid_q <= nxt_valid_d;
            rd_en_q <= rd_en_d;
            rd_pend_q <= rd_pend_d;
            play_entry_q <= play_entry_d;
            idx_q <= idx_d;
            ampl_q <= ampl_d;
            done_q <= done_d;
            underrun_q <= underrun_d;
        end
    end

    assign fifo_rd_en = rd_en_q;
    assign ampl = ampl_q;
    assign busy = (state_q != IDLE);
    assign underrun = underrun_q;
    assign done = done_q;
endmodule

// File: tb/tb_sample_playback_streamer.sv
// tb_sample_playback_streamer: directed playback scenarios with a FIFO model and
// a scoreboard of expected samples checked as the DUT output changes.
module tb_sample_playback_streamer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        play_trig = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] rate_div = '0;
    logic [31:0] total_samples = '0;
    logic [31:0] fifo_dout = '0;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd_en, busy, underrun, done;
    logic [11:0] ampl;

    logic [31:0] fq[$];
    logic [11:0] sbq[$];
    int          errors = 0, checks = 0;
    int          cyc = 0, last_cyc = 0, gap = 0, starts = 0, dones = 0, s0 = 0, d0 = 0;
    logic        have_last = 1'b0, rd_prev = 1'b0, busy_prev = 1'b0;
    logic [11:0] prev_ampl = 12'h080;

    sample_playback_streamer dut (
        .clk(clk), .reset_n(reset_n), .play_trig(play_trig), .stop(stop),
        .rate_div(rate_div), .total_samples(total_samples), .fifo_dout(fifo_dout),
        .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .ampl(ampl), .busy(busy),
        .underrun(underrun), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one clock: serve FIFO reads, then compare any new sample with the scoreboard
    task automatic step();
        logic [11:0] e;
        @(negedge clk);
        cyc++;
        if (fifo_rd_en) begin
            chk("rd_spacing", {31'b0, rd_prev}, 32'd0);
            if (fq.size() > 0) fifo_dout = fq.pop_front();
            fifo_empty = (fq.size() == 0);
        end
        rd_prev = fifo_rd_en;
        if (busy && !busy_prev) starts++;
        busy_prev = busy;
        if (done) dones++;
        if (ampl !== prev_ampl && ampl !== 12'h080) begin
            if (sbq.size() == 0) chk("unexpected_sample", {20'b0, ampl}, 32'h080);
            else begin
                e = sbq.pop_front();
                chk("sample", {20'b0, ampl}, {20'b0, e});
                if (gap != 0 && have_last) chk("sample_gap", cyc - last_cyc, gap);
                last_cyc = cyc;
                have_last = 1'b1;
            end
        end
        prev_ampl = ampl;
    endtask

    task automatic push_word(input logic [31:0] w);
        fq.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic exp_word(input logic [31:0] w);
        for (int j = 0; j < 4; j++) sbq.push_back({4'h0, w[8*j +: 8]});
    endtask

    task automatic trigger();
        play_trig = 1'b1;
        repeat (3) step();
        play_trig = 1'b0;
    endtask

    task automatic wait_q(input int n, input int budget);
        int k = 0;
        while (sbq.size() > n && k < budget) begin
            step();
            k++;
        end
        chk("scoreboard_drain", sbq.size(), n);
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        int d = dones;
        while (dones == d && k < budget) begin
            step();
            k++;
        end
        chk("done_pulse", dones - d, 1);
    endtask

    task automatic new_test(input int g);
        gap = g;
        have_last = 1'b0;
        sbq.delete();
    endtask

    initial begin
        logic [31:0] w;
        logic [7:0]  b;
        repeat (2) step();
        chk("rst_ampl", ampl, 32'h080);
        chk("rst_busy", busy, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_done", done, 0);
        chk("rst_underrun", underrun, 0);
        reset_n = 1'b1;
        step();

        // basic single word at rate 4
        new_test(4);
        push_word(32'h44332211);
        exp_word(32'h44332211);
        rate_div = 4;
        total_samples = 4;
        trigger();
        wait_done(200);
        chk("t1_all_samples", sbq.size(), 0);
        chk("t1_last_with_done", ampl, 32'h044);
        step();
        chk("t1_midscale", ampl, 32'h080);
        chk("t1_busy", busy, 0);
        chk("t1_underrun", underrun, 0);

        // continuous at one sample per clock
        new_test(1);
        for (int k = 0; k < 8; k++) begin
            b = 8'(4 * k + 1);
            w = {b + 8'd3, b + 8'd2, b + 8'd1, b};
            push_word(w);
            exp_word(w);
        end
        rate_div = 0;
        total_samples = 0;
        trigger();
        wait_q(0, 200);
        chk("t2_underrun", underrun, 0);
        chk("t2_fifo_drained", fq.size(), 0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("t2_stop_busy", busy, 0);
        chk("t2_stop_ampl", ampl, 32'h080);

        // underrun and resume
        new_test(0);
        push_word(32'h44332211);
        exp_word(32'h44332211);
        exp_word(32'h88776655);
        rate_div = 2;
        total_samples = 8;
        trigger();
        chk("t3_underrun_cleared", underrun, 0);
        wait_q(4, 200);
        repeat (6) step();
        chk("t3_hold", ampl, 32'h044);
        chk("t3_underrun", underrun, 1);
        chk("t3_busy", busy, 1);
        push_word(32'h88776655);
        wait_done(200);
        chk("t3_all_samples", sbq.size(), 0);
        step();
        chk("t3_midscale", ampl, 32'h080);

        // stop mid-play
        new_test(3);
        push_word(32'h34333231);
        push_word(32'h38373635);
        push_word(32'h3c3b3a39);
        sbq.push_back(12'h031);
        sbq.push_back(12'h032);
        sbq.push_back(12'h033);
        rate_div = 3;
        total_samples = 0;
        d0 = dones;
        trigger();
        wait_q(0, 200);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("t4_busy", busy, 0);
        chk("t4_ampl", ampl, 32'h080);
        repeat (5) step();
        chk("t4_no_done", dones - d0, 0);
        chk("t4_fifo_left", fq.size(), 1);
        fq.delete();
        fifo_empty = 1'b1;

        // asynchronous reset mid-play
        new_test(2);
        push_word(32'h54535251);
        push_word(32'h58575655);
        sbq.push_back(12'h051);
        sbq.push_back(12'h052);
        rate_div = 2;
        total_samples = 0;
        trigger();
        wait_q(0, 200);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_ampl", ampl, 32'h080);
        chk("t5_busy", busy, 0);
        chk("t5_rd_en", fifo_rd_en, 0);
        chk("t5_done", done, 0);
        chk("t5_underrun", underrun, 0);
        step();
        reset_n = 1'b1;
        s0 = starts;
        repeat (10) step();
        chk("t5_stay_idle", busy, 0);
        chk("t5_no_start", starts - s0, 0);
        fq.delete();
        fifo_empty = 1'b1;

        // async one-cycle trigger, then a retrigger while busy
        new_test(3);
        push_word(32'h14131211);
        exp_word(32'h14131211);
        rate_div = 3;
        total_samples = 4;
        s0 = starts;
        #3 play_trig = 1'b1;
        #10 play_trig = 1'b0;
        wait_q(2, 200);
        trigger();
        wait_done(200);
        chk("t6_all_samples", sbq.size(), 0);
        repeat (10) step();
        chk("t6_busy", busy, 0);
        chk("t6_one_start", starts - s0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
